// File: rtl/psum_tile_sched.sv
// Tile sequencer for one output pixel: issues one macro request per input-channel tile,
// accumulates the partial_sum vectors with saturation and hands the result downstream.
module psum_tile_sched #(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 20,
   parameter int CH      = 64,
   parameter int TILE_W  = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [TILE_W-1:0]        num_tiles,
   output logic                     macro_req,
   output logic [TILE_W-1:0]        tile_idx,
   input  logic                     psum_e,
   input  logic signed [DATA_W-1:0] psum_in [CH-1:0],
   output logic signed [ACC_W-1:0]  acc_out [CH-1:0],
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     err_timeout
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [TILE_W-1:0]        tile_idx_q, tile_idx_d;
   logic [TILE_W-1:0]        last_q, last_d;
   logic [TMR_W-1:0]         timer_q, timer_d;
   logic                     macro_req_q, macro_req_d;
   logic                     out_valid_q, out_valid_d;
   logic                     err_q, err_d;
   logic signed [ACC_W-1:0]  acc_q [CH-1:0];
   logic signed [ACC_W-1:0]  acc_d [CH-1:0];
   logic signed [ACC_W-1:0]  acc_sat [CH-1:0];
   logic signed [ACC_W:0]    sum [CH-1:0];

   // One guard bit is enough: a sign mismatch between the top two bits means overflow.
   always_comb begin
      for (int k = 0; k < CH; k++) begin
         sum[k] = {acc_q[k][ACC_W-1], acc_q[k]}
                + {{(ACC_W+1-DATA_W){psum_in[k][DATA_W-1]}}, psum_in[k]};
         if (sum[k][ACC_W] != sum[k][ACC_W-1])
            acc_sat[k] = sum[k][ACC_W] ? ACC_MIN : ACC_MAX;
         else
            acc_sat[k] = sum[k][ACC_W-1:0];
      end
   end

   // Handshakes: a pixel or a result transfers on a rising edge where valid and ready are
   // both high; out_valid and acc_out stay stable until that edge.
   always_comb begin
      state_d    = state_q;
      tile_idx_d = tile_idx_q;
      last_d     = last_q;
      timer_d    = timer_q;
      err_d      = err_q;
      acc_d      = acc_q;
      if (!mode) begin
         state_d = S_IDLE;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pix_valid) begin
                  last_d     = (num_tiles == '0) ? '0 : num_tiles - TILE_W'(1);
                  tile_idx_d = '0;
                  for (int k = 0; k < CH; k++) acc_d[k] = '0;
                  state_d    = S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer_d = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (psum_e) begin
                  acc_d = acc_sat;
                  if (tile_idx_q == last_q) begin
                     state_d = S_DONE;
                  end else begin
                     tile_idx_d = tile_idx_q + TILE_W'(1);
                     state_d    = S_ISSUE;
                  end
               end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      macro_req_d = (state_d == S_ISSUE);
      out_valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tile_idx_q  <= '0;
         last_q      <= '0;
         timer_q     <= '0;
         macro_req_q <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         for (int k = 0; k < CH; k++) acc_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         tile_idx_q  <= tile_idx_d;
         last_q      <= last_d;
         timer_q     <= timer_d;
         macro_req_q <= macro_req_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
      end
   end

   assign pix_ready   = (state_q == S_IDLE) && mode;
   assign busy        = (state_q != S_IDLE);
   assign macro_req   = macro_req_q;
   assign out_valid   = out_valid_q;
   assign tile_idx    = tile_idx_q;
   assign err_timeout = err_q;
   assign acc_out     = acc_q;

endmodule

// File: tb/tb_psum_tile_sched.sv
// Bench for psum_tile_sched: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level reference model and a result queue.
module tb_psum_tile_sched;

   localparam int DATA_W  = 16;
   localparam int ACC_W   = 17;
   localparam int CH      = 64;
   localparam int TILE_W  = 4;
   localparam int TIMEOUT = 16;

   logic                     clk;
   logic                     rst_n;
   logic                     mode;
   logic                     pix_valid;
   logic                     pix_ready;
   logic [TILE_W-1:0]        num_tiles;
   logic                     macro_req;
   logic [TILE_W-1:0]        tile_idx;
   logic                     psum_e;
   logic signed [DATA_W-1:0] psum_in [CH-1:0];
   logic signed [ACC_W-1:0]  acc_out [CH-1:0];
   logic                     out_valid;
   logic                     out_ready;
   logic                     busy;
   logic                     err_timeout;

   psum_tile_sched #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CH(CH), .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .num_tiles(num_tiles), .macro_req(macro_req), .tile_idx(tile_idx), .psum_e(psum_e),
      .psum_in(psum_in), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err_timeout(err_timeout)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: actual %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- responder (macro array + partial_sum stand-in) ----------------
   bit resp_en   = 1'b1;
   bit rand_lat  = 1'b0;
   bit noise_en  = 1'b0;
   int lat       = 2;
   int data_kind = 0;
   int manual_req = 0;
   int last_psum [CH];
   int seq_tbl [4] = '{32767, 32767, 32767, -32768};

   initial begin
      int cd = 0;
      int manual_seen = 0;
      bit fire;
      psum_e = 1'b0;
      for (int k = 0; k < CH; k++) psum_in[k] = '0;
      forever begin
         @(posedge clk); #1;
         fire   = 1'b0;
         psum_e = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) fire = 1'b1;
         end
         if (manual_req != manual_seen) begin
            manual_seen = manual_req;
            fire = 1'b1;
         end
         if (noise_en && $urandom_range(0, 15) == 0) fire = 1'b1;
         if (macro_req && resp_en) cd = rand_lat ? int'($urandom_range(1, 20)) : lat;
         if (fire) begin
            psum_e = 1'b1;
            for (int k = 0; k < CH; k++) begin
               case (data_kind)
                  0:       last_psum[k] = k;
                  1:       last_psum[k] = 32767;
                  2:       last_psum[k] = -32768;
                  3:       last_psum[k] = seq_tbl[int'(tile_idx) % 4];
                  default: last_psum[k] = int'($urandom_range(0, 65535)) - 32768;
               endcase
               psum_in[k] = last_psum[k][DATA_W-1:0];
            end
         end
      end
   end

   // ---------------- reference model ----------------
   bit m_busy, m_req, m_result, m_err;
   int m_tile, m_ntiles, m_waited;
   int m_acc [CH];
   logic [ACC_W-1:0] exp_q [$];
   int req_log [$];

   function automatic int clamp(input int v);
      int hi = (1 << (ACC_W - 1)) - 1;
      int lo = -(1 << (ACC_W - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task m_reset();
      m_busy = 0; m_req = 0; m_result = 0; m_err = 0;
      m_tile = 0; m_ntiles = 1; m_waited = 0;
      for (int k = 0; k < CH; k++) m_acc[k] = 0;
      exp_q.delete();
   endtask

   task m_step();
      if (!mode) begin
         if (m_result) void'(exp_q.pop_back());
         m_busy = 0; m_req = 0; m_result = 0; m_err = 0;
      end else if (!m_busy) begin
         if (pix_valid) begin
            m_busy = 1; m_req = 1; m_tile = 0;
            m_ntiles = (num_tiles == 0) ? 1 : int'(num_tiles);
            for (int k = 0; k < CH; k++) m_acc[k] = 0;
         end
      end else if (m_req) begin
         m_req = 0; m_waited = 0;
      end else if (m_result) begin
         if (out_ready) begin m_result = 0; m_busy = 0; end
      end else if (psum_e) begin
         for (int k = 0; k < CH; k++) m_acc[k] = clamp(m_acc[k] + int'(psum_in[k]));
         if (m_tile == m_ntiles - 1) begin
            m_result = 1;
            exp_q.push_back(m_acc[CH-1][ACC_W-1:0]);
         end else begin
            m_tile++; m_req = 1;
         end
      end else begin
         m_waited++;
         if (m_waited == TIMEOUT) begin m_err = 1; m_busy = 0; end
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   // ---------------- per-cycle compare + scoreboard ----------------
   initial begin
      int bad;
      logic [ACC_W-1:0] e;
      forever begin
         @(negedge clk);
         chk(macro_req === m_req, "macro_req", int'(macro_req), int'(m_req));
         chk(out_valid === m_result, "out_valid", int'(out_valid), int'(m_result));
         chk(busy === m_busy, "busy", int'(busy), int'(m_busy));
         chk(pix_ready === (!m_busy && mode), "pix_ready", int'(pix_ready), int'(!m_busy && mode));
         chk(err_timeout === m_err, "err_timeout", int'(err_timeout), int'(m_err));
         chk(int'(tile_idx) == m_tile, "tile_idx", int'(tile_idx), m_tile);
         bad = -1;
         for (int k = CH - 1; k >= 0; k--) if (int'(acc_out[k]) != m_acc[k]) bad = k;
         if (bad < 0) chk(1'b1, "acc_out", 0, 0);
         else chk(1'b0, $sformatf("acc_out[%0d]", bad), int'(acc_out[bad]), m_acc[bad]);
         if (macro_req) req_log.push_back(int'(tile_idx));
         if (out_valid && out_ready && mode && rst_n) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "sb_unexpected_result", int'(acc_out[CH-1]), 0);
            end else begin
               e = exp_q.pop_front();
               chk(acc_out[CH-1] == e, "sb_result", int'(acc_out[CH-1]), int'($signed(e)));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_pixel(input int nt, input bit hold);
      int n = 0;
      bit took = 1'b0;
      pix_valid = 1'b1;
      num_tiles = nt[TILE_W-1:0];
      while (!took && n < 200) begin
         @(negedge clk);
         took = pix_ready;
         n++;
         @(posedge clk); #1;
      end
      chk(took, "pix_accept", int'(took), 1);
      if (!hold) pix_valid = 1'b0;
   endtask

   task automatic wait_result(input string name);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(out_valid === 1'b1, {name, "_result_seen"}, int'(out_valid), 1);
   endtask

   function automatic bit acc_all(input int v);
      for (int k = 0; k < CH; k++) if (int'(acc_out[k]) != v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic sat_case(input int kind, input int nt, input int expv, input string name);
      step();
      data_kind = kind;
      send_pixel(nt, 1'b0);
      wait_result(name);
      chk(acc_all(expv), name, int'(acc_out[0]), expv);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int a0;
      bit ok;
      rst_n = 1'b0; mode = 1'b1; pix_valid = 1'b0; num_tiles = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk(!out_valid && !macro_req && !err_timeout && !busy && tile_idx == 0 && acc_all(0),
          "reset_state", int'(busy), 0);
      rst_n = 1'b1;

      // normal accumulate: acc_out[k] = 3k
      step();
      req_log.delete();
      data_kind = 0; lat = 2; out_ready = 1'b1;
      send_pixel(3, 1'b0);
      wait_result("normal");
      ok = 1'b1;
      for (int k = 0; k < CH; k++) if (int'(acc_out[k]) != 3 * k) ok = 1'b0;
      chk(ok, "normal_acc", int'(acc_out[5]), 15);
      chk(req_log.size() == 3 && req_log[0] == 0 && req_log[1] == 1 && req_log[2] == 2,
          "normal_tiles", req_log.size(), 3);
      @(negedge clk);
      chk(!out_valid && pix_ready, "normal_valid_one_cycle", int'(out_valid), 0);

      // saturation
      sat_case(1, 3, 65535, "sat_pos");
      sat_case(2, 3, -65536, "sat_neg");
      sat_case(3, 4, 32767, "sat_mixed");

      // backpressure
      step();
      data_kind = 0; out_ready = 1'b0;
      send_pixel(1, 1'b1);
      wait_result("bp");
      a0 = int'(acc_out[7]);
      chk(a0 == 7, "bp_acc", a0, 7);
      for (int i = 0; i < 5; i++) begin
         chk(out_valid && !pix_ready && int'(acc_out[7]) == a0, "bp_hold", int'(acc_out[7]), a0);
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk(pix_ready && !out_valid, "bp_release", int'(pix_ready), 1);
      @(negedge clk);
      chk(macro_req === 1'b1, "bp_next_accept", int'(macro_req), 1);
      @(posedge clk); #1;
      pix_valid = 1'b0;
      wait_result("bp2");

      // timeout
      repeat (3) step();
      resp_en = 1'b0;
      send_pixel(2, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!macro_req && n < 20);
      n = 0;
      do begin @(negedge clk); n++; end while (!err_timeout && n < 40);
      chk(n == 17, "timeout_latency", n, 17);
      chk(!busy && !out_valid, "timeout_idle", int'(busy), 0);
      step();
      manual_req++;
      resp_en = 1'b1;
      repeat (3) step();
      chk(int'(acc_out[3]) == 0 && !busy && !out_valid, "late_psum_ignored", int'(acc_out[3]), 0);

      // mode drop during WAIT of tile 1
      lat = 4;
      send_pixel(3, 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (!(macro_req && tile_idx == 1) && n < 100);
      chk(err_timeout === 1'b1, "err_sticky", int'(err_timeout), 1);
      @(posedge clk); #1;
      mode = 1'b0;
      step();
      chk(!busy && !macro_req && !err_timeout, "mode_drop", int'({busy, macro_req, err_timeout}), 0);
      mode = 1'b1;
      repeat (6) step();

      // num_tiles = 0 behaves as one tile
      req_log.delete();
      data_kind = 4; lat = 3;
      send_pixel(0, 1'b0);
      wait_result("zero_tiles");
      chk(req_log.size() == 1, "zero_tiles_reqs", req_log.size(), 1);
      ok = 1'b1;
      for (int k = 0; k < CH; k++) if (int'(acc_out[k]) != last_psum[k]) ok = 1'b0;
      chk(ok, "zero_tiles_acc", int'(acc_out[0]), last_psum[0]);

      // asynchronous reset while a result is pending
      step();
      data_kind = 0; lat = 2; out_ready = 1'b0;
      send_pixel(2, 1'b0);
      wait_result("rst_mid");
      chk(tile_idx == 1 && int'(acc_out[9]) == 18, "rst_pre", int'(acc_out[9]), 18);
      #2;
      rst_n = 1'b0;
      #1;
      chk(!out_valid && tile_idx == 0 && acc_all(0) && !busy, "rst_async", int'(out_valid), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // randomized traffic
      data_kind = 4; rand_lat = 1'b1; noise_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         mode      = ($urandom_range(0, 99) != 0);
         pix_valid = $urandom_range(0, 1) == 1;
         num_tiles = TILE_W'($urandom_range(0, 5));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      mode = 1'b1; pix_valid = 1'b0; out_ready = 1'b1; noise_en = 1'b0;
      repeat (150) step();
      chk(exp_q.size() == 0 && !busy, "drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
